// File: rtl/dl_router_if.sv
// dl_router_if: hps_io ioctl download bus.
//   ioctl_download  download in progress
//   ioctl_wr        byte strobe
//   ioctl_addr      byte address (AW bits)
//   ioctl_dout      byte data
//   ioctl_index     download index
// master = hps_io side (drives), slave = dl_router side (samples).
interface dl_router_if #(
    parameter int AW = 25
) ();
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );

    modport slave (
        input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );
endinterface

// File: rtl/dl_router.sv
// dl_router: decodes the hps_io ioctl byte stream.
//   - ROM bytes are routed to one of REGIONS dpram regions (base/size per region)
//     as a registered one-hot write strobe plus region-local offset and data.
//   - DIP bytes and the core-variant (mod) byte are captured.
//   - The ROM download lifecycle is tracked: byte count, checksum,
//     unmapped-address error and a one-cycle completion pulse.
// Ports:
//   clk_sys, reset (synchronous, active-high)
//   io            ioctl bus (slave modport)
//   rom_wr/rom_addr/rom_data   region write port, latency 1
//   dip, mod, mod_valid        captured configuration bytes
//   dl_active, dl_done, byte_count, checksum, err_unmapped   download status
//
// state  | meaning
// IDLE   | no ROM download in progress
// LOAD   | ROM download in progress, bytes routed and counted
// FINISH | download ended, dl_done high for this one cycle
module dl_router #(
    parameter int                    REGIONS     = 4,
    parameter int                    AW          = 25,
    parameter logic [REGIONS*AW-1:0] REGION_BASE = '0,
    parameter logic [REGIONS*5-1:0]  REGION_LOG2 = '0,
    parameter int                    ROM_INDEX   = 0,
    parameter int                    MOD_INDEX   = 1,
    parameter int                    DIP_INDEX   = 254,
    parameter int                    DIP_BYTES   = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    dl_router_if.slave             io,
    output logic [REGIONS-1:0]     rom_wr,
    output logic [AW-1:0]          rom_addr,
    output logic [7:0]             rom_data,
    output logic [8*DIP_BYTES-1:0] dip,
    output logic [7:0]             mod,
    output logic                   mod_valid,
    output logic                   dl_active,
    output logic                   dl_done,
    output logic [AW:0]            byte_count,
    output logic [7:0]             checksum,
    output logic                   err_unmapped
);

    typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] CNT_MAX = '1;

    state_t state, state_nxt;

    logic               is_rom, is_mod, is_dip;
    logic               start, rom_take;
    logic [REGIONS-1:0] hit;
    logic               hit_any;
    logic [AW-1:0]      hit_off;
    logic [AW-1:0]      base_i, off_i;

    assign is_rom = (io.ioctl_index == 8'(ROM_INDEX));
    assign is_mod = (io.ioctl_index == 8'(MOD_INDEX));
    assign is_dip = (io.ioctl_index == 8'(DIP_INDEX));

    // A byte arriving on the very cycle the download starts is already part of it.
    assign start    = (state == IDLE) && io.ioctl_download && is_rom;
    // In LOAD the byte coinciding with the falling download edge is still taken.
    assign rom_take = io.ioctl_wr && is_rom && ((state == LOAD) || start);

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dl_active = 1'b0;
        dl_done   = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD: begin
                dl_active = 1'b1;
                if (!io.ioctl_download) state_nxt = FINISH;
            end
            FINISH: begin
                dl_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Region decode. Lowest index wins on overlap. The offset shifted right by
    // log2(size) is zero exactly when the address lies inside the region; a log2
    // of AW or more makes the region cover everything above its base.
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_off = '0;
        base_i  = '0;
        off_i   = '0;
        for (int i = 0; i < REGIONS; i++) begin
            base_i = REGION_BASE[i*AW +: AW];
            off_i  = io.ioctl_addr - base_i;
            if (!hit_any && (io.ioctl_addr >= base_i) &&
                ((off_i >> REGION_LOG2[i*5 +: 5]) == '0)) begin
                hit[i]  = 1'b1;
                hit_any = 1'b1;
                hit_off = off_i;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_wr       <= '0;
            rom_addr     <= '0;
            rom_data     <= '0;
            byte_count   <= '0;
            checksum     <= '0;
            err_unmapped <= 1'b0;
        end else begin
            rom_wr <= '0;
            if (start) begin
                byte_count   <= '0;
                checksum     <= '0;
                err_unmapped <= 1'b0;
            end
            if (rom_take) begin
                rom_wr <= hit;
                if (hit_any) begin
                    rom_addr <= hit_off;
                    rom_data <= io.ioctl_dout;
                end else begin
                    err_unmapped <= 1'b1;
                end
                if (start)                   byte_count <= CNT_ONE;
                else if (byte_count != CNT_MAX) byte_count <= byte_count + CNT_ONE;
                checksum <= start ? io.ioctl_dout : checksum + io.ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dip       <= '0;
            mod       <= '0;
            mod_valid <= 1'b0;
        end else begin
            for (int k = 0; k < DIP_BYTES; k++) begin
                if (io.ioctl_wr && is_dip && (io.ioctl_addr == AW'(k)))
                    dip[k*8 +: 8] <= io.ioctl_dout;
            end
            if (io.ioctl_wr && is_mod) begin
                mod       <= io.ioctl_dout;
                mod_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dl_router.sv
// Bench for dl_router: two instances share one ioctl bus.
//   dut_a: 3 regions 0x0000/32K, 0xE000/4K, 0xFF00/256
//   dut_b: 2 regions both 0x0000/256 (overlap)
// A behavioural model (region table lookup, counters as plain ints) predicts
// every output of both instances; directed sections add literal expectations.
module tb_dl_router;

    localparam int AW = 16;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    dl_router_if #(.AW(AW)) ioc ();

    logic [2:0]    rom_wr_a;
    logic [AW-1:0] rom_addr_a;
    logic [7:0]    rom_data_a, mod_a, checksum_a;
    logic [63:0]   dip_a;
    logic          mod_valid_a, dl_active_a, dl_done_a, err_a;
    logic [AW:0]   byte_count_a;

    logic [1:0]    rom_wr_b;
    logic [AW-1:0] rom_addr_b;
    logic [7:0]    rom_data_b, mod_b, checksum_b;
    logic [63:0]   dip_b;
    logic          mod_valid_b, dl_active_b, dl_done_b, err_b;
    logic [AW:0]   byte_count_b;

    dl_router #(
        .REGIONS(3), .AW(AW),
        .REGION_BASE({16'hFF00, 16'hE000, 16'h0000}),
        .REGION_LOG2({5'd8, 5'd12, 5'd15})
    ) dut_a (
        .clk_sys(clk_sys), .reset(reset), .io(ioc),
        .rom_wr(rom_wr_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .dip(dip_a), .mod(mod_a), .mod_valid(mod_valid_a),
        .dl_active(dl_active_a), .dl_done(dl_done_a),
        .byte_count(byte_count_a), .checksum(checksum_a), .err_unmapped(err_a)
    );

    dl_router #(
        .REGIONS(2), .AW(AW),
        .REGION_BASE({16'h0000, 16'h0000}),
        .REGION_LOG2({5'd8, 5'd8})
    ) dut_b (
        .clk_sys(clk_sys), .reset(reset), .io(ioc),
        .rom_wr(rom_wr_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .dip(dip_b), .mod(mod_b), .mod_valid(mod_valid_b),
        .dl_active(dl_active_b), .dl_done(dl_done_b),
        .byte_count(byte_count_b), .checksum(checksum_b), .err_unmapped(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_nreg [2]    = '{3, 2};
    longint m_base [2][3] = '{'{0, 'hE000, 'hFF00}, '{0, 0, 0}};
    int     m_log2 [2][3] = '{'{15, 12, 8}, '{8, 8, 0}};

    int ph    [2];            // 0 idle, 1 downloading, 2 finishing
    int e_wr  [2], e_addr [2], e_data [2], e_cnt [2], e_sum [2], e_mod [2];
    bit e_err [2], e_modv [2];
    int e_dip [2][8];

    bit m_rom, m_take;
    int m_nph, m_r;
    longint m_a;

    always @(posedge clk_sys) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                ph[m] = 0; e_wr[m] = 0; e_addr[m] = 0; e_data[m] = 0;
                e_cnt[m] = 0; e_sum[m] = 0; e_err[m] = 0; e_mod[m] = 0; e_modv[m] = 0;
                for (int k = 0; k < 8; k++) e_dip[m][k] = 0;
            end else begin
                m_a    = longint'(ioc.ioctl_addr);
                m_rom  = (ioc.ioctl_index == 8'd0);
                m_take = ioc.ioctl_wr && m_rom &&
                         (ph[m] == 1 || (ph[m] == 0 && ioc.ioctl_download));
                m_nph  = ph[m];
                if (ph[m] == 0 && ioc.ioctl_download && m_rom) begin
                    m_nph = 1; e_cnt[m] = 0; e_sum[m] = 0; e_err[m] = 0;
                end else if (ph[m] == 1 && !ioc.ioctl_download) m_nph = 2;
                else if (ph[m] == 2) m_nph = 0;
                e_wr[m] = 0;
                if (m_take) begin
                    m_r = -1;
                    for (int i = 0; i < m_nreg[m]; i++)
                        if (m_r < 0 && m_a >= m_base[m][i] &&
                            m_a < m_base[m][i] + (longint'(1) << m_log2[m][i]))
                            m_r = i;
                    if (m_r >= 0) begin
                        e_wr[m]   = 1 << m_r;
                        e_addr[m] = int'(m_a - m_base[m][m_r]);
                        e_data[m] = int'(ioc.ioctl_dout);
                    end else e_err[m] = 1;
                    if (e_cnt[m] < (1 << (AW+1)) - 1) e_cnt[m]++;
                    e_sum[m] = (e_sum[m] + int'(ioc.ioctl_dout)) % 256;
                end
                if (ioc.ioctl_wr && ioc.ioctl_index == 8'd254 && m_a < 8)
                    e_dip[m][int'(m_a)] = int'(ioc.ioctl_dout);
                if (ioc.ioctl_wr && ioc.ioctl_index == 8'd1) begin
                    e_mod[m] = int'(ioc.ioctl_dout); e_modv[m] = 1;
                end
                ph[m] = m_nph;
            end
        end
    end

    function automatic logic [63:0] exp_dip(input int m);
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(e_dip[m][k]);
        return v;
    endfunction

    // One compare process: every cycle, all outputs of both instances.
    always @(negedge clk_sys) begin
        chk("a.rom_wr",     64'(rom_wr_a),     64'(e_wr[0]));
        chk("a.rom_addr",   64'(rom_addr_a),   64'(e_addr[0]));
        chk("a.rom_data",   64'(rom_data_a),   64'(e_data[0]));
        chk("a.byte_count", 64'(byte_count_a), 64'(e_cnt[0]));
        chk("a.checksum",   64'(checksum_a),   64'(e_sum[0]));
        chk("a.err",        64'(err_a),        64'(e_err[0]));
        chk("a.dl_active",  64'(dl_active_a),  64'(ph[0] == 1));
        chk("a.dl_done",    64'(dl_done_a),    64'(ph[0] == 2));
        chk("a.dip",        dip_a,             exp_dip(0));
        chk("a.mod",        64'(mod_a),        64'(e_mod[0]));
        chk("a.mod_valid",  64'(mod_valid_a),  64'(e_modv[0]));
        chk("b.rom_wr",     64'(rom_wr_b),     64'(e_wr[1]));
        chk("b.rom_addr",   64'(rom_addr_b),   64'(e_addr[1]));
        chk("b.rom_data",   64'(rom_data_b),   64'(e_data[1]));
        chk("b.byte_count", 64'(byte_count_b), 64'(e_cnt[1]));
        chk("b.checksum",   64'(checksum_b),   64'(e_sum[1]));
        chk("b.err",        64'(err_b),        64'(e_err[1]));
        chk("b.dl_active",  64'(dl_active_b),  64'(ph[1] == 1));
        chk("b.dl_done",    64'(dl_done_b),    64'(ph[1] == 2));
        chk("b.dip",        dip_b,             exp_dip(1));
        chk("b.mod",        64'(mod_b),        64'(e_mod[1]));
        chk("b.mod_valid",  64'(mod_valid_b),  64'(e_modv[1]));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input bit dl, input bit wr, input int idx, input int addr, input int dout);
        ioc.ioctl_download = dl;
        ioc.ioctl_wr       = wr;
        ioc.ioctl_index    = 8'(idx);
        ioc.ioctl_addr     = AW'(addr);
        ioc.ioctl_dout     = 8'(dout);
    endtask

    int edge_addrs [14] = '{0, 'h7FFF, 'h8000, 'h9000, 'hDFFF, 'hE000, 'hEFFF,
                            'hF000, 'hFEFF, 'hFF00, 'hFFFF, 'hFF, 'h100, 2};
    int idx_pool [6] = '{0, 0, 0, 1, 254, 7};
    bit r_dl;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        // reset state
        chk("rst.rom_wr", 64'(rom_wr_a), 64'h0);
        chk("rst.byte_count", 64'(byte_count_a), 64'h0);
        chk("rst.mod_valid", 64'(mod_valid_a), 64'h0);
        chk("rst.dl_active", 64'(dl_active_a), 64'h0);
        reset = 1'b0;

        // DIP / mod
        drive(0, 1, 254, 2, 'h3C); cyc();
        drive(0, 1, 254, 9, 'h77); cyc();
        drive(0, 1, 1, 0, 'h04);   cyc();
        drive(0, 0, 0, 0, 0);      cyc();
        chk("dipmod.dip", dip_a, 64'h0000_0000_003C_0000);
        chk("dipmod.mod", 64'(mod_a), 64'h04);
        chk("dipmod.mod_valid", 64'(mod_valid_a), 64'h1);
        chk("dipmod.dl_active", 64'(dl_active_a), 64'h0);

        // region routing
        drive(1, 0, 0, 0, 0);         cyc();
        chk("route.dl_active", 64'(dl_active_a), 64'h1);
        drive(1, 1, 0, 'h0010, 'hA5); cyc();
        chk("route.wr0", 64'(rom_wr_a), 64'b001);
        chk("route.off0", 64'(rom_addr_a), 64'h10);
        chk("route.data0", 64'(rom_data_a), 64'hA5);
        drive(1, 1, 0, 'hE003, 'h5A); cyc();
        chk("route.wr1", 64'(rom_wr_a), 64'b010);
        chk("route.off1", 64'(rom_addr_a), 64'h3);
        drive(1, 1, 0, 'hFF01, 'h11); cyc();
        chk("route.wr2", 64'(rom_wr_a), 64'b100);
        chk("route.off2", 64'(rom_addr_a), 64'h1);
        drive(0, 0, 0, 0, 0);         cyc();
        chk("route.dl_done", 64'(dl_done_a), 64'h1);
        chk("route.byte_count", 64'(byte_count_a), 64'd3);
        chk("route.checksum", 64'(checksum_a), 64'h10);
        chk("route.err", 64'(err_a), 64'h0);
        cyc();
        chk("route.dl_done_once", 64'(dl_done_a), 64'h0);

        // unmapped byte, then cleared by next download
        drive(1, 0, 0, 0, 0);         cyc();
        drive(1, 1, 0, 'h9000, 'h22); cyc();
        chk("unmap.rom_wr", 64'(rom_wr_a), 64'h0);
        chk("unmap.err", 64'(err_a), 64'h1);
        chk("unmap.count", 64'(byte_count_a), 64'd1);
        drive(0, 0, 0, 0, 0); cyc(); cyc();
        drive(1, 0, 0, 0, 0); cyc();
        chk("unmap.err_cleared", 64'(err_a), 64'h0);
        chk("unmap.count_cleared", 64'(byte_count_a), 64'd0);

        // overlap and checksum wrap (dut_b)
        drive(1, 1, 0, 'h00FF, 'hFF); cyc();
        chk("ovl.rom_wr", 64'(rom_wr_b), 64'b01);
        chk("ovl.off", 64'(rom_addr_b), 64'hFF);
        for (int i = 1; i < 300; i++) begin
            drive(1, 1, 0, i % 256, 'hFF); cyc();
        end
        drive(0, 0, 0, 0, 0); cyc();
        chk("ovl.checksum", 64'(checksum_b), 64'hD4);
        chk("ovl.count", 64'(byte_count_b), 64'd300);
        cyc();

        // reset mid-download
        drive(1, 0, 0, 0, 0); cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, i, i + 1); cyc();
        end
        drive(1, 0, 0, 0, 0);
        reset = 1'b1; cyc();
        chk("rstmid.count", 64'(byte_count_a), 64'd0);
        chk("rstmid.dl_active", 64'(dl_active_a), 64'h0);
        chk("rstmid.mod_valid", 64'(mod_valid_a), 64'h0);
        chk("rstmid.dip", dip_a, 64'h0);
        drive(0, 0, 0, 0, 0); cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rstmid.no_done", 64'(dl_done_a), 64'h0);
        end
        // new download with a byte on its first cycle
        drive(1, 1, 0, 'h10, 'h07); cyc();
        chk("new.count", 64'(byte_count_a), 64'd1);
        chk("new.checksum", 64'(checksum_a), 64'h07);
        chk("new.dl_active", 64'(dl_active_a), 64'h1);

        // write coinciding with falling download
        drive(0, 1, 0, 'h20, 'h33); cyc();
        chk("edge.rom_wr", 64'(rom_wr_a), 64'b001);
        chk("edge.off", 64'(rom_addr_a), 64'h20);
        chk("edge.count", 64'(byte_count_a), 64'd2);
        chk("edge.checksum", 64'(checksum_a), 64'h3A);
        chk("edge.dl_done", 64'(dl_done_a), 64'h1);
        drive(0, 0, 0, 0, 0); cyc();

        // randomized traffic, model checks every cycle
        r_dl = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) r_dl = !r_dl;
            reset = ($urandom_range(0, 199) == 0);
            drive(r_dl, bit'($urandom_range(0, 1)),
                  idx_pool[$urandom_range(0, 5)],
                  ($urandom_range(0, 1) == 1) ? edge_addrs[$urandom_range(0, 13)]
                                              : int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 255)));
            cyc();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
